hack_cpu_ctrl: RTL and testbench



---
 rtl/hack_cpu_ctrl_if.sv | 29 ++
 rtl/hack_cpu_ctrl.sv | 54 +++++
 tb/tb_hack_cpu_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hack_cpu_ctrl_if.sv
// hack_cpu_ctrl_if: bus bundle between the Hack controller and its ROM, RAM and ALU.
// Carries the fetch handshake (instr, instr_valid, instr_req, pc), the RAM port
// (inM, inM_valid, outM, writeM, addressM) and the ALU link (alu_x, alu_y,
// zx..no, alu_out, zr, ng).
interface hack_cpu_ctrl_if #(parameter int N = 16, parameter int PCW = 15);
  logic [N-1:0]   instr;
  logic           instr_valid;
  logic           instr_req;
  logic [PCW-1:0] pc;
  logic [N-1:0]   inM;
  logic           inM_valid;
  logic [N-1:0]   outM;
  logic           writeM;
  logic [PCW-1:0] addressM;
  logic [N-1:0]   alu_x;
  logic [N-1:0]   alu_y;
  logic           zx, nx, zy, ny, f, no;
  logic [N-1:0]   alu_out;
  logic           zr;
  logic           ng;
  modport master (
    input  instr, instr_valid, inM, inM_valid, alu_out, zr, ng,
    output instr_req, pc, outM, writeM, addressM, alu_x, alu_y, zx, nx, zy, ny, f, no
  );
  modport slave (
    output instr, instr_valid, inM, inM_valid, alu_out, zr, ng,
    input  instr_req, pc, outM, writeM, addressM, alu_x, alu_y, zx, nx, zy, ny, f, no
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: Hack CPU sequencer (FETCH/MREAD/EXEC) holding A, D, IR, M latch and PC.
// Ports: clk, rst_n (async active-low), bus (master side of hack_cpu_ctrl_if:
// ROM fetch handshake, RAM read/write port, ALU operands/controls and result flags).
module hack_cpu_ctrl #(parameter int N = 16, parameter int PCW = 15) (
  input logic clk,
  input logic rst_n,
  hack_cpu_ctrl_if.master bus
);
  typedef enum logic [1:0] {FETCH, MREAD, EXEC} state_t;
  state_t state, state_nx;
  logic [N-1:0] a_reg, d_reg, m_lat, ir;
  logic [PCW-1:0] pc_reg, pc_nx;
  logic jump;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      a_reg  <= '0;
      d_reg  <= '0;
      m_lat  <= '0;
      ir     <= '0;
      pc_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && bus.instr_valid) ir <= bus.instr;
      if (state == MREAD && bus.inM_valid) m_lat <= bus.inM;
      if (state == EXEC) begin
        if (!ir[15]) a_reg <= ir;
        else if (ir[5]) a_reg <= bus.alu_out;
        if (ir[15] && ir[4]) d_reg <= bus.alu_out;
        pc_reg <= pc_nx;
      end
    end
  end
  always_comb begin
    state_nx = FETCH;
    if (state == FETCH)
      state_nx = bus.instr_valid ? ((bus.instr[15] && bus.instr[12]) ? MREAD : EXEC) : FETCH;
    else if (state == MREAD)
      state_nx = bus.inM_valid ? EXEC : MREAD;
  end
  // pc_nx reads a_reg before the EXEC edge, so a same-cycle A write never affects the jump target
  always_comb begin
    jump  = ir[15] & ((ir[2] & bus.ng) | (ir[1] & bus.zr) | (ir[0] & ~bus.ng & ~bus.zr));
    pc_nx = jump ? a_reg[PCW-1:0] : pc_reg + 1'b1;
  end
  assign bus.instr_req = (state == FETCH);
  assign bus.pc        = pc_reg;
  assign bus.addressM  = a_reg[PCW-1:0];
  assign bus.outM      = bus.alu_out;
  assign bus.writeM    = (state == EXEC) & ir[15] & ir[3];
  assign bus.alu_x     = d_reg;
  assign bus.alu_y     = ir[12] ? m_lat : a_reg;
  assign {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ir[11:6];
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: directed bench for hack_cpu_ctrl with a behavioural Hack ALU.
module tb_hack_cpu_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int mread_bad = 0;
  logic [5:0]  snap_ctrl;
  logic [15:0] snap_y, snap_out;
  logic [14:0] snap_addr;
  logic        snap_wr;
  logic [15:0] x0, x1, y0, y1, r0;
  hack_cpu_ctrl_if bus();
  hack_cpu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    x0 = bus.zx ? 16'h0 : bus.alu_x;
    x1 = bus.nx ? ~x0 : x0;
    y0 = bus.zy ? 16'h0 : bus.alu_y;
    y1 = bus.ny ? ~y0 : y0;
    r0 = bus.f ? x1 + y1 : x1 & y1;
    bus.alu_out = bus.no ? ~r0 : r0;
    bus.zr = (bus.alu_out == 16'h0);
    bus.ng = bus.alu_out[15];
  end
  always @(negedge clk) if (bus.writeM) wr_cnt++;
  task automatic run(input logic [15:0] w, input int wm, input logic [15:0] mv);
    @(negedge clk);
    bus.instr = w;
    bus.instr_valid = 1;
    @(negedge clk);
    bus.instr_valid = 0;
    bus.instr = 16'h0;
    if (w[15] && w[12]) begin
      for (int i = 0; i < wm; i++) begin
        if (bus.writeM || bus.instr_req) mread_bad++;
        @(negedge clk);
      end
      if (bus.writeM || bus.instr_req) mread_bad++;
      bus.inM = mv;
      bus.inM_valid = 1;
      @(negedge clk);
      bus.inM_valid = 0;
    end
    snap_ctrl = {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
    snap_y = bus.alu_y;
    snap_out = bus.outM;
    snap_addr = bus.addressM;
    snap_wr = bus.writeM;
    @(negedge clk);
  endtask
  task automatic test_reset();
    #7;
    checks++; if (bus.pc !== 15'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.pc); end
    checks++; if (bus.addressM !== 15'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.addressM); end
    checks++; if (bus.alu_x !== 16'd0 || bus.alu_y !== 16'd0) begin errors++; $display("FAIL reset_ops: got %h/%h expected 0/0", bus.alu_x, bus.alu_y); end
    checks++; if ({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got nonzero expected 000000"); end
    checks++; if (bus.writeM !== 1'b0 || bus.instr_req !== 1'b1) begin errors++; $display("FAIL reset_strobes: got wr=%b req=%b expected 0/1", bus.writeM, bus.instr_req); end
    checks++; if (bus.outM !== 16'd0) begin errors++; $display("FAIL reset_outM: got %h expected 0", bus.outM); end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_a_instr();
    run(16'h0015, 0, 16'h0);
    checks++; if (bus.addressM !== 15'd21) begin errors++; $display("FAIL a_instr_A: got %0d expected 21", bus.addressM); end
    checks++; if (bus.pc !== 15'd1) begin errors++; $display("FAIL a_instr_pc: got %0d expected 1", bus.pc); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL a_instr_wr: got %0d expected 0", wr_cnt); end
    checks++; if (bus.instr_req !== 1'b1) begin errors++; $display("FAIL a_instr_latency: got req=%b expected 1", bus.instr_req); end
  endtask
  task automatic test_c_dreg();
    run(16'hEC10, 0, 16'h0);
    checks++; if (snap_ctrl !== 6'b110000) begin errors++; $display("FAIL dreg_ctrl: got %b expected 110000", snap_ctrl); end
    checks++; if (snap_y !== 16'd21) begin errors++; $display("FAIL dreg_y: got %0d expected 21", snap_y); end
    checks++; if (bus.alu_x !== 16'd21) begin errors++; $display("FAIL dreg_D: got %0d expected 21", bus.alu_x); end
    checks++; if (bus.pc !== 15'd2) begin errors++; $display("FAIL dreg_pc: got %0d expected 2", bus.pc); end
  endtask
  task automatic test_mwrite();
    int w0;
    run(16'h0064, 0, 16'h0);
    w0 = wr_cnt;
    run(16'hE7C8, 0, 16'h0);
    checks++; if (snap_wr !== 1'b1 || snap_out !== 16'd22 || snap_addr !== 15'd100) begin errors++; $display("FAIL mwrite_exec: got wr=%b out=%0d addr=%0d expected 1/22/100", snap_wr, snap_out, snap_addr); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL mwrite_pulses: got %0d expected 1", wr_cnt - w0); end
    checks++; if (bus.addressM !== 15'd100 || bus.alu_x !== 16'd21) begin errors++; $display("FAIL mwrite_regs: got A=%0d D=%0d expected 100/21", bus.addressM, bus.alu_x); end
    checks++; if (bus.pc !== 15'd4) begin errors++; $display("FAIL mwrite_pc: got %0d expected 4", bus.pc); end
  endtask
  task automatic test_mread();
    int w0;
    w0 = wr_cnt;
    run(16'hFDE8, 3, 16'd7);
    checks++; if (mread_bad !== 0) begin errors++; $display("FAIL mread_wait: got %0d bad cycles expected 0", mread_bad); end
    checks++; if (snap_wr !== 1'b1 || snap_out !== 16'd8 || snap_addr !== 15'd100) begin errors++; $display("FAIL mread_exec: got wr=%b out=%0d addr=%0d expected 1/8/100", snap_wr, snap_out, snap_addr); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL mread_pulses: got %0d expected 1", wr_cnt - w0); end
    checks++; if (bus.addressM !== 15'd8 || bus.alu_x !== 16'd21) begin errors++; $display("FAIL mread_regs: got A=%0d D=%0d expected 8/21", bus.addressM, bus.alu_x); end
    checks++; if (bus.pc !== 15'd5) begin errors++; $display("FAIL mread_pc: got %0d expected 5", bus.pc); end
  endtask
  task automatic test_jumps();
    run(16'd5, 0, 16'h0);
    run(16'hEC10, 0, 16'h0);
    run(16'd40, 0, 16'h0);
    run(16'hE301, 0, 16'h0);
    checks++; if (bus.pc !== 15'd40) begin errors++; $display("FAIL jgt_taken: got %0d expected 40", bus.pc); end
    run(16'd0, 0, 16'h0);
    run(16'hEC10, 0, 16'h0);
    run(16'd40, 0, 16'h0);
    run(16'hE301, 0, 16'h0);
    checks++; if (bus.pc !== 15'd44) begin errors++; $display("FAIL jgt_not_taken: got %0d expected 44", bus.pc); end
    run(16'hEA87, 0, 16'h0);
    checks++; if (bus.pc !== 15'd40) begin errors++; $display("FAIL jmp: got %0d expected 40", bus.pc); end
    run(16'd50, 0, 16'h0);
    run(16'hE302, 0, 16'h0);
    checks++; if (bus.pc !== 15'd50) begin errors++; $display("FAIL jeq_taken: got %0d expected 50", bus.pc); end
    run(16'hEAA7, 0, 16'h0);
    checks++; if (bus.pc !== 15'd50 || bus.addressM !== 15'd0) begin errors++; $display("FAIL jmp_old_A: got pc=%0d A=%0d expected 50/0", bus.pc, bus.addressM); end
  endtask
  task automatic test_wrap();
    run(16'h7FFF, 0, 16'h0);
    run(16'hEA87, 0, 16'h0);
    checks++; if (bus.pc !== 15'h7FFF) begin errors++; $display("FAIL wrap_setup: got %h expected 7fff", bus.pc); end
    run(16'hEC10, 0, 16'h0);
    checks++; if (bus.pc !== 15'd0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", bus.pc); end
    checks++; if (bus.alu_x !== 16'h7FFF) begin errors++; $display("FAIL wrap_D: got %h expected 7fff", bus.alu_x); end
  endtask
  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    bus.instr = 16'hFDE8;
    bus.instr_valid = 1;
    @(negedge clk);
    bus.instr_valid = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (bus.pc !== 15'd0 || bus.addressM !== 15'd0 || bus.alu_x !== 16'd0) begin errors++; $display("FAIL rstmid_regs: got pc=%0d A=%0d D=%0d expected 0/0/0", bus.pc, bus.addressM, bus.alu_x); end
    checks++; if (bus.instr_req !== 1'b1 || bus.writeM !== 1'b0) begin errors++; $display("FAIL rstmid_state: got req=%b wr=%b expected 1/0", bus.instr_req, bus.writeM); end
    bus.inM = 16'd9;
    bus.inM_valid = 1;
    @(negedge clk);
    @(negedge clk);
    bus.inM_valid = 0;
    rst_n = 1;
    checks++; if (bus.pc !== 15'd0 || bus.instr_req !== 1'b1) begin errors++; $display("FAIL rstmid_resume: got pc=%0d req=%b expected 0/1", bus.pc, bus.instr_req); end
    run(16'd7, 0, 16'h0);
    checks++; if (bus.pc !== 15'd1 || bus.addressM !== 15'd7) begin errors++; $display("FAIL rstmid_after: got pc=%0d A=%0d expected 1/7", bus.pc, bus.addressM); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 0", wr_cnt - w0); end
  endtask
  initial begin
    bus.instr = 16'h0;
    bus.instr_valid = 0;
    bus.inM = 16'h0;
    bus.inM_valid = 0;
    test_reset();
    test_a_instr();
    test_c_dreg();
    test_mwrite();
    test_mread();
    test_jumps();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
